// File: rtl/sav_ioctl_upload.sv
// sav_ioctl_upload: streams the cartridge backup RAM to the HPS during an ioctl upload.
//
// The core is halted (sav_req/sav_ack) for the duration of the transfer. Each
// ioctl_rd byte request is served either from the backup RAM or with PAD.
// PAD is used when the address is beyond the RAM, or when the core never
// acknowledged the halt. A saturating byte counter detects a complete dump, so
// the dirty flag is only cleared by a full save.
//
// Optional feature: define SAV_CHECKSUM_EN to build a 16-bit running sum of
// every byte driven on ioctl_din; otherwise sav_sum is tied to zero.
//
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   ioctl_upload              high for the whole upload transfer
//   ioctl_rd, ioctl_addr      single-cycle byte request and its byte address
//   ioctl_din, ioctl_wait     returned byte, valid when ioctl_wait is low
//   sav_req, sav_ack          halt handshake with the system core
//   ram_addr, ram_rd, ram_q   backup RAM read port (RAM_LAT cycles latency)
//   sram_we                   core write strobe to backup RAM (sets dirty)
//   sav_dirty                 RAM modified since the last complete upload
//   status_err                sticky errors: [0] overrun, [1] halt timeout
//   sav_sum                   running byte checksum
module sav_ioctl_upload #(
   parameter int         AW      = 15,
   parameter int         RAM_LAT = 1,
   parameter logic [7:0] PAD     = 8'hFF,
   parameter int         HALT_TO = 1024
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_upload,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          sav_req,
   input  logic          sav_ack,
   output logic [AW-1:0] ram_addr,
   output logic          ram_rd,
   input  logic [7:0]    ram_q,
   input  logic          sram_we,
   output logic          sav_dirty,
   output logic [1:0]    status_err,
   output logic [15:0]   sav_sum
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_HALT    = 3'd1;
   localparam logic [2:0] S_READY   = 3'd2;
   localparam logic [2:0] S_FETCH   = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;
   localparam int         TW        = $clog2(HALT_TO + 1);

   logic [2:0]    state_q, state_d;
   logic [7:0]    ioctl_din_q, ioctl_din_d;
   logic          ioctl_wait_q, ioctl_wait_d;
   logic          sav_req_q, sav_req_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          ram_rd_q, ram_rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [1:0]    status_err_q, status_err_d;
   logic          pad_q, pad_d;
   logic [2:0]    lat_q, lat_d;
   logic [TW-1:0] to_q, to_d;
   logic          sav_dirty_q, sav_dirty_d;
   logic          upload_q;
   logic          in_range, abort;
`ifdef SAV_CHECKSUM_EN
   logic [15:0]   sav_sum_q, sav_sum_d;
`endif

   assign in_range = (ioctl_addr >> AW) == 25'd0;
   // Upload dropping in any active state aborts the transfer at once.
   assign abort = (state_q == S_HALT || state_q == S_READY || state_q == S_FETCH) && !ioctl_upload;

   always_comb begin
      state_d      = state_q;
      ioctl_din_d  = ioctl_din_q;
      ioctl_wait_d = ioctl_wait_q;
      sav_req_d    = sav_req_q;
      ram_addr_d   = ram_addr_q;
      ram_rd_d     = 1'b0;
      cnt_d        = cnt_q;
      status_err_d = status_err_q;
      pad_d        = pad_q;
      lat_d        = lat_q;
      to_d         = to_q;
`ifdef SAV_CHECKSUM_EN
      sav_sum_d    = sav_sum_q;
`endif
      if (abort) begin
         state_d      = S_RELEASE;
         ioctl_wait_d = 1'b0;
         sav_req_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ioctl_upload && !upload_q) begin
                  state_d      = S_HALT;
                  sav_req_d    = 1'b1;
                  ioctl_wait_d = 1'b1;
                  cnt_d        = '0;
                  status_err_d = 2'b00;
                  pad_d        = 1'b0;
                  to_d         = '0;
`ifdef SAV_CHECKSUM_EN
                  sav_sum_d    = 16'h0000;
`endif
               end
            end
            S_HALT: begin
               if (ioctl_rd) status_err_d[0] = 1'b1;
               if (sav_ack) begin
                  state_d      = S_READY;
                  ioctl_wait_d = 1'b0;
               end else if (to_q == TW'(HALT_TO - 1)) begin
                  // Core never released the RAM: serve the rest of this upload as PAD.
                  state_d         = S_READY;
                  ioctl_wait_d    = 1'b0;
                  status_err_d[1] = 1'b1;
                  pad_d           = 1'b1;
               end else begin
                  to_d = to_q + TW'(1);
               end
            end
            S_READY: begin
               if (ioctl_rd && !pad_q && in_range) begin
                  state_d      = S_FETCH;
                  ram_addr_d   = ioctl_addr[AW-1:0];
                  ram_rd_d     = 1'b1;
                  ioctl_wait_d = 1'b1;
                  lat_d        = 3'd0;
               end else if (ioctl_rd) begin
                  ioctl_din_d = PAD;
`ifdef SAV_CHECKSUM_EN
                  sav_sum_d   = sav_sum_q + {8'h00, PAD};
`endif
               end
            end
            S_FETCH: begin
               if (ioctl_rd) status_err_d[0] = 1'b1;
               if (lat_q == 3'(RAM_LAT)) begin
                  state_d      = S_READY;
                  ioctl_din_d  = ram_q;
                  ioctl_wait_d = 1'b0;
                  cnt_d        = cnt_q[AW] ? cnt_q : cnt_q + (AW+1)'(1);
`ifdef SAV_CHECKSUM_EN
                  sav_sum_d    = sav_sum_q + {8'h00, ram_q};
`endif
               end else begin
                  lat_d = lat_q + 3'd1;
               end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end
      // A core write in the same cycle as a completed-upload clear must win.
      sav_dirty_d = sram_we ? 1'b1 : (abort && cnt_q[AW]) ? 1'b0 : sav_dirty_q;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         ioctl_din_q  <= 8'h00;
         ioctl_wait_q <= 1'b0;
         sav_req_q    <= 1'b0;
         ram_addr_q   <= '0;
         ram_rd_q     <= 1'b0;
         cnt_q        <= '0;
         status_err_q <= 2'b00;
         pad_q        <= 1'b0;
         lat_q        <= 3'd0;
         to_q         <= '0;
         sav_dirty_q  <= 1'b0;
         upload_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         ioctl_din_q  <= ioctl_din_d;
         ioctl_wait_q <= ioctl_wait_d;
         sav_req_q    <= sav_req_d;
         ram_addr_q   <= ram_addr_d;
         ram_rd_q     <= ram_rd_d;
         cnt_q        <= cnt_d;
         status_err_q <= status_err_d;
         pad_q        <= pad_d;
         lat_q        <= lat_d;
         to_q         <= to_d;
         sav_dirty_q  <= sav_dirty_d;
         upload_q     <= ioctl_upload;
      end
   end

`ifdef SAV_CHECKSUM_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) sav_sum_q <= 16'h0000;
      else          sav_sum_q <= sav_sum_d;
   end
   assign sav_sum = sav_sum_q;
`else
   assign sav_sum = 16'h0000;
`endif

   assign ioctl_din  = ioctl_din_q;
   assign ioctl_wait = ioctl_wait_q;
   assign sav_req    = sav_req_q;
   assign ram_addr   = ram_addr_q;
   assign ram_rd     = ram_rd_q;
   assign sav_dirty  = sav_dirty_q;
   assign status_err = status_err_q;

endmodule

// File: tb/tb_sav_ioctl_upload.sv
// tb_sav_ioctl_upload: directed self-checking bench for sav_ioctl_upload (256-byte RAM build).
module tb_sav_ioctl_upload;

   localparam int AW = 8;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic          ioctl_upload = 1'b0;
   logic          ioctl_rd = 1'b0;
   logic [24:0]   ioctl_addr = '0;
   logic [7:0]    ioctl_din;
   logic          ioctl_wait;
   logic          sav_req;
   logic          sav_ack = 1'b0;
   logic [AW-1:0] ram_addr;
   logic          ram_rd;
   logic [7:0]    ram_q = 8'h00;
   logic          sram_we = 1'b0;
   logic          sav_dirty;
   logic [1:0]    status_err;
   logic [15:0]   sav_sum;

   int compared = 0;
   int mismatched = 0;
   int rd_pulses = 0;

   sav_ioctl_upload #(.AW(AW), .RAM_LAT(1), .PAD(8'hFF), .HALT_TO(1024)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
      .ioctl_wait(ioctl_wait), .sav_req(sav_req), .sav_ack(sav_ack),
      .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q), .sram_we(sram_we),
      .sav_dirty(sav_dirty), .status_err(status_err), .sav_sum(sav_sum)
   );

   always #5 clk_sys = ~clk_sys;

   // Backup RAM model: content is addr[7:0], one cycle read latency.
   always @(posedge clk_sys) begin
      if (ram_rd) begin
         ram_q     <= ram_addr;
         rd_pulses <= rd_pulses + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic start_upload(input bit ack, output int n);
      @(negedge clk_sys) ioctl_upload = 1'b1;
      @(negedge clk_sys);
      n = 0;
      if (ack) begin
         repeat (2) @(negedge clk_sys);
         sav_ack = 1'b1;
      end
      while (ioctl_wait && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
   endtask

   task automatic end_upload(input bit we);
      @(negedge clk_sys);
      ioctl_upload = 1'b0;
      sram_we = we;
      @(negedge clk_sys);
      sram_we = 1'b0;
      sav_ack = 1'b0;
   endtask

   task automatic do_read(input logic [24:0] a, output logic [7:0] d, output int lat);
      @(negedge clk_sys);
      ioctl_rd = 1'b1;
      ioctl_addr = a;
      @(negedge clk_sys) ioctl_rd = 1'b0;
      lat = 0;
      while (ioctl_wait && lat < 20) begin
         @(negedge clk_sys);
         lat++;
      end
      d = ioctl_din;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk_sys);
      compared++;
      if ({ioctl_din, ioctl_wait, sav_req, ram_rd} !== 11'd0) begin
         mismatched++;
         $display("FAIL reset_io: got din=%h wait=%b req=%b rd=%b required 0", ioctl_din, ioctl_wait, sav_req, ram_rd);
      end
      compared++;
      if ({ram_addr, sav_dirty, status_err, sav_sum} !== 27'd0) begin
         mismatched++;
         $display("FAIL reset_state: got addr=%h dirty=%b err=%b sum=%h required 0", ram_addr, sav_dirty, status_err, sav_sum);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      compared++;
      if ({ioctl_wait, sav_req} !== 2'b00) begin
         mismatched++;
         $display("FAIL idle_after_reset: got wait=%b req=%b required 0 0", ioctl_wait, sav_req);
      end
   endtask

   task automatic test_full_upload;
      int n, lat, p0;
      logic [7:0] d;
      @(negedge clk_sys) sram_we = 1'b1;
      @(negedge clk_sys) sram_we = 1'b0;
      compared++;
      if (sav_dirty !== 1'b1) begin
         mismatched++;
         $display("FAIL dirty_set: got %b required 1", sav_dirty);
      end
      start_upload(1'b1, n);
      compared++;
      if (sav_req !== 1'b1 || n >= 2000) begin
         mismatched++;
         $display("FAIL upload_start: got req=%b cycles=%0d required req=1 cycles<2000", sav_req, n);
      end
      p0 = rd_pulses;
      for (int i = 0; i < 256; i++) begin
         do_read(25'(i), d, lat);
         compared++;
         if (d !== 8'(i)) begin
            mismatched++;
            $display("FAIL byte_%0d: got %h required %h", i, d, 8'(i));
         end
         compared++;
         if (lat !== 2) begin
            mismatched++;
            $display("FAIL latency_%0d: got %0d required 2", i, lat);
         end
      end
      compared++;
      if (rd_pulses - p0 !== 256) begin
         mismatched++;
         $display("FAIL ram_rd_count: got %0d required 256", rd_pulses - p0);
      end
      @(negedge clk_sys) ioctl_upload = 1'b0;
      compared++;
      if (sav_req !== 1'b1) begin
         mismatched++;
         $display("FAIL req_before_fall: got %b required 1", sav_req);
      end
      @(negedge clk_sys);
      sav_ack = 1'b0;
      compared++;
      if (sav_req !== 1'b0) begin
         mismatched++;
         $display("FAIL req_drop: got %b required 0", sav_req);
      end
      compared++;
      if (sav_dirty !== 1'b0) begin
         mismatched++;
         $display("FAIL dirty_clear: got %b required 0", sav_dirty);
      end
      compared++;
      if (status_err !== 2'b00) begin
         mismatched++;
         $display("FAIL err_clean: got %b required 00", status_err);
      end
   endtask

   task automatic test_set_wins;
      int n, lat, bad;
      logic [7:0] d;
      @(negedge clk_sys) sram_we = 1'b1;
      @(negedge clk_sys) sram_we = 1'b0;
      start_upload(1'b1, n);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         do_read(25'(i), d, lat);
         if (d !== 8'(i) || lat !== 2) bad++;
      end
      compared++;
      if (bad !== 0) begin
         mismatched++;
         $display("FAIL set_wins_bytes: got %0d bad bytes required 0", bad);
      end
      end_upload(1'b1);
      compared++;
      if (sav_dirty !== 1'b1) begin
         mismatched++;
         $display("FAIL dirty_set_wins: got %b required 1", sav_dirty);
      end
   endtask

   task automatic test_partial;
      int n, lat;
      logic [7:0] d;
      start_upload(1'b1, n);
      for (int i = 0; i < 100; i++) do_read(25'(i), d, lat);
      compared++;
      if (d !== 8'd99) begin
         mismatched++;
         $display("FAIL partial_last_byte: got %h required 63", d);
      end
      end_upload(1'b0);
      compared++;
      if (sav_dirty !== 1'b1) begin
         mismatched++;
         $display("FAIL dirty_partial: got %b required 1", sav_dirty);
      end
   endtask

   task automatic test_pad_addr;
      int n, lat, p0;
      logic [7:0] d;
      start_upload(1'b1, n);
      p0 = rd_pulses;
      do_read(25'h8000, d, lat);
      compared++;
      if (d !== 8'hFF || lat !== 0) begin
         mismatched++;
         $display("FAIL pad_8000: got %h lat=%0d required ff lat=0", d, lat);
      end
      do_read(25'h100, d, lat);
      compared++;
      if (d !== 8'hFF || lat !== 0) begin
         mismatched++;
         $display("FAIL pad_100: got %h lat=%0d required ff lat=0", d, lat);
      end
      compared++;
      if (rd_pulses !== p0) begin
         mismatched++;
         $display("FAIL pad_no_ram_rd: got %0d pulses required 0", rd_pulses - p0);
      end
      do_read(25'h5, d, lat);
      compared++;
      if (d !== 8'h05 || lat !== 2) begin
         mismatched++;
         $display("FAIL in_range_after_pad: got %h lat=%0d required 05 lat=2", d, lat);
      end
      end_upload(1'b0);
   endtask

   task automatic test_overrun;
      int n, lat, p0;
      start_upload(1'b1, n);
      p0 = rd_pulses;
      @(negedge clk_sys);
      ioctl_rd = 1'b1;
      ioctl_addr = 25'h10;
      @(negedge clk_sys);
      ioctl_addr = 25'h20;
      @(negedge clk_sys) ioctl_rd = 1'b0;
      lat = 0;
      while (ioctl_wait && lat < 20) begin
         @(negedge clk_sys);
         lat++;
      end
      compared++;
      if (ioctl_din !== 8'h10) begin
         mismatched++;
         $display("FAIL overrun_byte: got %h required 10", ioctl_din);
      end
      compared++;
      if (status_err !== 2'b01) begin
         mismatched++;
         $display("FAIL overrun_err: got %b required 01", status_err);
      end
      compared++;
      if (rd_pulses - p0 !== 1) begin
         mismatched++;
         $display("FAIL overrun_ram_rd: got %0d required 1", rd_pulses - p0);
      end
      end_upload(1'b0);
      compared++;
      if (status_err !== 2'b01) begin
         mismatched++;
         $display("FAIL err_sticky: got %b required 01", status_err);
      end
   endtask

   task automatic test_timeout;
      int n, lat, p0;
      logic [7:0] d;
      @(negedge clk_sys) ioctl_upload = 1'b1;
      @(negedge clk_sys);
      compared++;
      if (status_err !== 2'b00 || ioctl_wait !== 1'b1 || sav_req !== 1'b1) begin
         mismatched++;
         $display("FAIL halt_entry: got err=%b wait=%b req=%b required 00 1 1", status_err, ioctl_wait, sav_req);
      end
      n = 0;
      while (ioctl_wait && n < 2000) begin
         @(negedge clk_sys);
         n++;
      end
      compared++;
      if (n < 1020 || n > 1030) begin
         mismatched++;
         $display("FAIL timeout_cycles: got %0d required about 1024", n);
      end
      compared++;
      if (status_err !== 2'b10) begin
         mismatched++;
         $display("FAIL timeout_err: got %b required 10", status_err);
      end
      p0 = rd_pulses;
      do_read(25'h3, d, lat);
      compared++;
      if (d !== 8'hFF || lat !== 0) begin
         mismatched++;
         $display("FAIL timeout_pad_3: got %h lat=%0d required ff lat=0", d, lat);
      end
      do_read(25'h8000, d, lat);
      compared++;
      if (d !== 8'hFF) begin
         mismatched++;
         $display("FAIL timeout_pad_8000: got %h required ff", d);
      end
      compared++;
      if (rd_pulses !== p0) begin
         mismatched++;
         $display("FAIL timeout_no_ram_rd: got %0d pulses required 0", rd_pulses - p0);
      end
      end_upload(1'b0);
   endtask

   task automatic test_checksum;
      int n, lat;
      logic [7:0] d1, d2, d3;
      start_upload(1'b1, n);
      do_read(25'h1, d1, lat);
      do_read(25'h2, d2, lat);
      do_read(25'h8000, d3, lat);
      compared++;
      if ({d1, d2, d3} !== 24'h0102FF) begin
         mismatched++;
         $display("FAIL checksum_bytes: got %h %h %h required 01 02 ff", d1, d2, d3);
      end
`ifdef SAV_CHECKSUM_EN
      compared++;
      if (sav_sum !== 16'h0102) begin
         mismatched++;
         $display("FAIL checksum: got %h required 0102", sav_sum);
      end
      end_upload(1'b0);
      compared++;
      if (sav_sum !== 16'h0102) begin
         mismatched++;
         $display("FAIL checksum_hold: got %h required 0102", sav_sum);
      end
`else
      compared++;
      if (sav_sum !== 16'h0000) begin
         mismatched++;
         $display("FAIL checksum_tied: got %h required 0000", sav_sum);
      end
      end_upload(1'b0);
`endif
   endtask

   task automatic test_async_reset;
      int n;
      start_upload(1'b1, n);
      @(negedge clk_sys);
      ioctl_rd = 1'b1;
      ioctl_addr = 25'h7;
      @(negedge clk_sys) ioctl_rd = 1'b0;
      compared++;
      if (ioctl_wait !== 1'b1 || ram_rd !== 1'b1) begin
         mismatched++;
         $display("FAIL fetch_precondition: got wait=%b rd=%b required 1 1", ioctl_wait, ram_rd);
      end
      #2 reset_n = 1'b0;
      #1;
      compared++;
      if ({ioctl_din, ioctl_wait, sav_req, ram_rd} !== 11'd0) begin
         mismatched++;
         $display("FAIL async_reset_io: got din=%h wait=%b req=%b rd=%b required 0", ioctl_din, ioctl_wait, sav_req, ram_rd);
      end
      compared++;
      if ({ram_addr, sav_dirty, status_err, sav_sum} !== 27'd0) begin
         mismatched++;
         $display("FAIL async_reset_state: got addr=%h dirty=%b err=%b sum=%h required 0", ram_addr, sav_dirty, status_err, sav_sum);
      end
      ioctl_upload = 1'b0;
      sav_ack = 1'b0;
      @(negedge clk_sys) reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);
   endtask

   initial begin
      test_reset;
      test_full_upload;
      test_set_wins;
      test_partial;
      test_pad_addr;
      test_overrun;
      test_timeout;
      test_checksum;
      test_async_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
